// File: rtl/card_dealer.sv
// card_dealer: 52-card deck source for the blackjack game.
// A used/unused bitmap tracks which cards are out of the deck. A draw takes its
// starting index from a free-running LFSR, then probes forward one bitmap entry
// per cycle, wrapping 51 -> 0, until it finds a card still in the deck.
module card_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_draw_req,
    input  logic       i_shuffle,
    output logic [3:0] o_card_value,
    output logic [1:0] o_card_symbol,
    output logic       o_card_valid,
    output logic       o_busy,
    output logic       o_deck_empty,
    output logic [5:0] o_cards_dealt,
    output logic       o_draw_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [51:0] r_used;
    logic [5:0]  r_idx;
    logic [5:0]  r_cards_dealt;
    logic [3:0]  r_card_value;
    logic [1:0]  r_card_symbol;
    logic        r_card_valid;
    logic        r_busy;
    logic        r_deck_empty;
    logic        r_draw_err;

    logic [5:0]  w_start_idx;
    logic [5:0]  w_next_idx;
    logic [5:0]  w_suit_base;
    logic [1:0]  w_symbol;
    logic [3:0]  w_value;
    logic        w_free;

    // Fold the 6-bit LFSR sample (0..63) into the 0..51 index range.
    assign w_start_idx = (r_lfsr[5:0] >= 6'd52) ? (r_lfsr[5:0] - 6'd52) : r_lfsr[5:0];
    assign w_next_idx  = (r_idx == 6'd51) ? 6'd0 : (r_idx + 6'd1);
    assign w_free      = ~r_used[r_idx];

    // Split the probe index into suit (idx / 13) and face value (idx % 13 + 1).
    always_comb begin
        w_symbol    = 2'd3;
        w_suit_base = 6'd39;
        if (r_idx < 6'd13) begin
            w_symbol    = 2'd0;
            w_suit_base = 6'd0;
        end else if (r_idx < 6'd26) begin
            w_symbol    = 2'd1;
            w_suit_base = 6'd13;
        end else if (r_idx < 6'd39) begin
            w_symbol    = 2'd2;
            w_suit_base = 6'd26;
        end
        w_value = 4'(r_idx - w_suit_base + 6'd1);
    end

    // Galois LFSR, right shift, taps 0xB400; runs every cycle regardless of state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Deal FSM: accepts commands in IDLE, probes the bitmap, flags the dealt card.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_used        <= '0;
            r_idx         <= '0;
            r_cards_dealt <= '0;
            r_card_value  <= '0;
            r_card_symbol <= '0;
            r_card_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_deck_empty  <= 1'b0;
            r_draw_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_card_valid <= 1'b0;
                    r_draw_err   <= 1'b0;
                    if (i_shuffle) begin
                        // Shuffle wins over a simultaneous draw; the draw is simply dropped.
                        r_used        <= '0;
                        r_cards_dealt <= '0;
                        r_deck_empty  <= 1'b0;
                    end else if (i_draw_req && r_deck_empty) begin
                        r_draw_err <= 1'b1;
                    end else if (i_draw_req) begin
                        r_idx   <= w_start_idx;
                        r_busy  <= 1'b1;
                        r_state <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (w_free) begin
                        r_used[r_idx] <= 1'b1;
                        r_cards_dealt <= r_cards_dealt + 6'd1;
                        r_deck_empty  <= (r_cards_dealt == 6'd51);
                        r_card_value  <= w_value;
                        r_card_symbol <= w_symbol;
                        r_card_valid  <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        // At least one card is free on entry, so this walk always ends.
                        r_idx <= w_next_idx;
                    end
                end
                S_DONE: begin
                    r_card_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_card_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_draw_err   <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign o_card_value  = r_card_value;
    assign o_card_symbol = r_card_symbol;
    assign o_card_valid  = r_card_valid;
    assign o_busy        = r_busy;
    assign o_deck_empty  = r_deck_empty;
    assign o_cards_dealt = r_cards_dealt;
    assign o_draw_err    = r_draw_err;

endmodule

// File: tb/tb_card_dealer.sv
// Testbench for card_dealer: a deck-level reference model predicts every output
// each cycle; directed scenarios add hand-computed literal expectations.
module tb_card_dealer;

    logic       clk;
    logic       rst;
    logic       draw_req;
    logic       shuffle;
    logic [3:0] card_value;
    logic [1:0] card_symbol;
    logic       card_valid;
    logic       busy;
    logic       deck_empty;
    logic [5:0] cards_dealt;
    logic       draw_err;

    int checks = 0;
    int errors = 0;

    card_dealer #(.LFSR_SEED(16'hACE1)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_draw_req    (draw_req),
        .i_shuffle     (shuffle),
        .o_card_value  (card_value),
        .o_card_symbol (card_symbol),
        .o_card_valid  (card_valid),
        .o_busy        (busy),
        .o_deck_empty  (deck_empty),
        .o_cards_dealt (cards_dealt),
        .o_draw_err    (draw_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Deck state plus a countdown of remaining busy cycles. The whole draw
    // (start index, collisions, chosen card) is resolved at acceptance time.
    logic [15:0] m_lfsr;
    bit          m_used [52];
    int          m_dealt;
    int          m_val, m_sym;
    bit          m_valid, m_err;
    int          m_remain;
    int          m_pidx;
    int          m_pk;
    int          m_wraps;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_lfsr = 16'hACE1;
                foreach (m_used[i]) m_used[i] = 1'b0;
                m_dealt = 0; m_val = 0; m_sym = 0;
                m_valid = 1'b0; m_err = 1'b0; m_remain = 0;
            end else begin
                int c, idx, k;
                bit wrapped;
                c = int'(m_lfsr[5:0]);
                m_lfsr = lfsr_next(m_lfsr);
                m_valid = 1'b0;
                m_err = 1'b0;
                if (m_remain > 0) begin
                    m_remain--;
                    if (m_remain == 1) begin
                        m_used[m_pidx] = 1'b1;
                        m_dealt++;
                        m_val = m_pidx % 13 + 1;
                        m_sym = m_pidx / 13;
                        m_valid = 1'b1;
                    end
                end else if (shuffle) begin
                    foreach (m_used[i]) m_used[i] = 1'b0;
                    m_dealt = 0;
                end else if (draw_req) begin
                    if (m_dealt == 52) begin
                        m_err = 1'b1;
                    end else begin
                        idx = (c >= 52) ? c - 52 : c;
                        k = 0;
                        wrapped = 1'b0;
                        while (m_used[idx]) begin
                            idx = (idx + 1) % 52;
                            if (idx == 0) wrapped = 1'b1;
                            k++;
                        end
                        if (wrapped) m_wraps++;
                        m_pidx = idx;
                        m_pk = k;
                        m_remain = k + 2;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_value",  int'(card_value),  m_val);
            check("cmp_symbol", int'(card_symbol), m_sym);
            check("cmp_valid",  int'(card_valid),  int'(m_valid));
            check("cmp_busy",   int'(busy),        (m_remain > 0) ? 1 : 0);
            check("cmp_empty",  int'(deck_empty),  (m_dealt == 52) ? 1 : 0);
            check("cmp_dealt",  int'(cards_dealt), m_dealt);
            check("cmp_err",    int'(draw_err),    int'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge in IDLE; returns at the negedge after DONE (IDLE again).
    task automatic do_draw(output int val, output int sym, output int lat);
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        lat = 1;
        while (!card_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!card_valid) begin
            check("draw_timeout", lat, 0);
            val = -1;
            sym = -1;
        end else begin
            val = int'(card_value);
            sym = int'(card_symbol);
            check("draw_latency", lat, m_pk + 2);
            $display("draw: value=%0d symbol=%0d latency=%0d dealt=%0d", val, sym, lat, cards_dealt);
        end
        @(negedge clk);
    endtask

    initial begin
        int v, s, l, idx;
        bit seen [52];
        bit dup;
        m_wraps  = 0;
        rst      = 1'b1;
        draw_req = 1'b0;
        shuffle  = 1'b0;
        foreach (seen[i]) seen[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", int'(card_valid), 0);
        check("reset_busy",  int'(busy), 0);
        check("reset_dealt", int'(cards_dealt), 0);
        check("reset_value", int'(card_value), 0);
        $display("reset: outputs idle");

        // Deterministic first draw: lfsr 0xACE1 -> c = 33 -> value 8, suit 2.
        rst = 1'b0;
        do_draw(v, s, l);
        check("first_value",   v, 8);
        check("first_symbol",  s, 2);
        check("first_latency", l, 2);
        check("first_dealt",   int'(cards_dealt), 1);
        seen[33] = 1'b1;

        // Remaining 51 draws: every card must be distinct.
        dup = 1'b0;
        for (int n = 0; n < 51; n++) begin
            do_draw(v, s, l);
            idx = s * 13 + v - 1;
            if (v < 1 || v > 13 || s < 0 || s > 3 || seen[idx]) dup = 1'b1;
            else seen[idx] = 1'b1;
        end
        check("deck_distinct", int'(dup), 0);
        check("full_dealt", int'(cards_dealt), 52);
        check("full_empty", int'(deck_empty), 1);
        $display("full deck: 52 cards dealt, %0d draws wrapped 51->0", m_wraps);

        // 53rd draw on an empty deck.
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        check("empty_err",   int'(draw_err), 1);
        check("empty_valid", int'(card_valid), 0);
        check("empty_busy",  int'(busy), 0);
        check("empty_dealt", int'(cards_dealt), 52);
        @(negedge clk);
        check("empty_err_pulse", int'(draw_err), 0);
        $display("empty draw: draw_err pulsed");

        // Shuffle, deal 10, then shuffle together with a draw request.
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        check("shuffle_dealt", int'(cards_dealt), 0);
        check("shuffle_empty", int'(deck_empty), 0);
        for (int n = 0; n < 10; n++) do_draw(v, s, l);
        check("ten_dealt", int'(cards_dealt), 10);
        shuffle  = 1'b1;
        draw_req = 1'b1;
        @(negedge clk);
        shuffle  = 1'b0;
        draw_req = 1'b0;
        check("shufdraw_dealt", int'(cards_dealt), 0);
        check("shufdraw_busy",  int'(busy), 0);
        check("shufdraw_err",   int'(draw_err), 0);
        check("shufdraw_valid", int'(card_valid), 0);
        @(negedge clk);
        check("shufdraw_valid2", int'(card_valid), 0);
        check("shufdraw_busy2",  int'(busy), 0);
        $display("shuffle+draw: draw dropped, deck refilled");

        // Asynchronous reset while probing.
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        check("probe_busy", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy",  int'(busy), 0);
        check("arst_valid", int'(card_valid), 0);
        check("arst_dealt", int'(cards_dealt), 0);
        check("arst_value", int'(card_value), 0);
        @(negedge clk);
        check("arst_valid2", int'(card_valid), 0);
        rst = 1'b0;
        do_draw(v, s, l);
        check("rearm_value",  v, 8);
        check("rearm_symbol", s, 2);
        check("rearm_dealt",  int'(cards_dealt), 1);
        $display("async reset in probe: aborted, redraw gives value=%0d symbol=%0d", v, s);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
